// File: rtl/lcd_scheduler.sv
// lcd_scheduler
//   Arbitrates LCD driver commands between a line requester, a queue of
//   character-write requests and an optional status-line requester. Each
//   command is issued as a one-cycle pulse, followed by HOLD_CYCLES idle
//   cycles so the LCD controller can finish it before the next command.
//
//   Configuration macro: LCD_SCHEDULER_STATUS_EN
//     defined   -> status requester takes part in arbitration (lowest priority)
//     undefined -> stat_req/stat_data ignored, stat_gnt tied low
//
// Ports
//   clk, reset            clock (rising edge), async active-low reset
//   line_req/line_data    line load request (level) and 8-char line
//   line_gnt              one-cycle grant, line_data captured this cycle
//   char_req/char_num     one-cycle push of a character position into queue
//   stat_req/stat_data    status line request (level) and line
//   stat_gnt              one-cycle grant, stat_data captured this cycle
//   lcd_wLineEn/lcd_line  line-load pulse and held line to the LCD driver
//   lcd_wEn/lcd_charNum   char-write pulse and held position
//   busy                  command in ISSUE or HOLD
//   fifo_count            queue occupancy
//   overflow              sticky, a char_req was dropped on a full queue
module lcd_scheduler #(
    parameter int HOLD_CYCLES = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_req,
    input  logic [63:0] line_data,
    output logic        line_gnt,
    input  logic        char_req,
    input  logic [3:0]  char_num,
    input  logic        stat_req,
    input  logic [63:0] stat_data,
    output logic        stat_gnt,
    output logic        lcd_wLineEn,
    output logic        lcd_wEn,
    output logic [3:0]  lcd_charNum,
    output logic [63:0] lcd_line,
    output logic        busy,
    output logic [3:0]  fifo_count,
    output logic        overflow
);

    localparam int           PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [7:0]   HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0]   DEPTH_C   = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t             state, state_next;
    logic [7:0]         hold_cnt;
    logic               armed;
    logic [3:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic               fifo_full, char_pop, push_ok, drop;
    logic               stat_req_en;
    logic [63:0]        stat_line;

`ifdef LCD_SCHEDULER_STATUS_EN
    assign stat_req_en = stat_req;
    assign stat_line   = stat_data;
`else
    logic unused_stat;
    assign unused_stat = ^{stat_req, stat_data};
    assign stat_req_en = 1'b0;
    assign stat_line   = '0;
`endif

    assign busy      = (state != IDLE);
    assign fifo_full = (fifo_count == DEPTH_C);

    // A line grant flushes the queue, so a simultaneous push is discarded
    // quietly; a pop in the same cycle frees the slot for the push.
    assign push_ok = char_req && !line_gnt && (!fifo_full || char_pop);
    assign drop    = char_req && !line_gnt && fifo_full && !char_pop;

    // armed is low for the first edge after reset release, so no grant can
    // be taken before the second rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            hold_cnt <= 8'd0;
            armed    <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
            if (state == ISSUE)
                hold_cnt <= HOLD_LAST;
            else if (state == HOLD && hold_cnt != 8'd0)
                hold_cnt <= hold_cnt - 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        line_gnt   = 1'b0;
        stat_gnt   = 1'b0;
        char_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (armed) begin
                    if (line_req) begin
                        line_gnt   = 1'b1;
                        state_next = ISSUE;
                    end else if (fifo_count != 4'd0) begin
                        char_pop   = 1'b1;
                        state_next = ISSUE;
                    end else if (stat_req_en) begin
                        stat_gnt   = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE:   state_next = HOLD;
            HOLD:    if (hold_cnt == 8'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Queue control
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= 4'd0;
            overflow   <= 1'b0;
        end else begin
            if (line_gnt) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_count <= 4'd0;
            end else begin
                if (push_ok)  wr_ptr <= wr_ptr + 1'b1;
                if (char_pop) rd_ptr <= rd_ptr + 1'b1;
                case ({push_ok, char_pop})
                    2'b10:   fifo_count <= fifo_count + 4'd1;
                    2'b01:   fifo_count <= fifo_count - 4'd1;
                    default: fifo_count <= fifo_count;
                endcase
            end
            if (drop) overflow <= 1'b1;
        end
    end

    // Queue storage needs no reset: occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= char_num;
    end

    // Issue stage: pulses and held data toward the LCD driver
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lcd_wLineEn <= 1'b0;
            lcd_wEn     <= 1'b0;
            lcd_charNum <= 4'd0;
            lcd_line    <= 64'h0;
        end else begin
            lcd_wLineEn <= line_gnt | stat_gnt;
            lcd_wEn     <= char_pop;
            if (line_gnt)
                lcd_line <= line_data;
            else if (stat_gnt)
                lcd_line <= stat_line;
            if (char_pop)
                lcd_charNum <= fifo_mem[rd_ptr];
        end
    end

endmodule

// File: doc/lcd_scheduler.md
LCD_SCHEDULER -- requirements
Module: lcd_scheduler

Interface
REQ-001 Parameter HOLD_CYCLES, default 16, range 1..255: idle cycles enforced after every LCD command pulse.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two 2..8: char-write queue depth.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 line_req  input  1  level; requester A wants line_data loaded as the new target line.
REQ-006 line_data  input  64  8 chars x 8 bits, char 0 in bits 63:56.
REQ-007 line_gnt  output  1  one-cycle pulse; line_data sampled this cycle.
REQ-008 char_req  input  1  one-cycle pulse; push char_num into queue.
REQ-009 char_num  input  4  character position to mark typed, 0..7.
REQ-010 stat_req  input  1  level; status message request.
REQ-011 stat_data  input  64  status line, same layout as line_data.
REQ-012 stat_gnt  output  1  one-cycle pulse; stat_data sampled this cycle.
REQ-013 lcd_wLineEn  output  1  one-cycle line-load pulse to LCD driver.
REQ-014 lcd_wEn  output  1  one-cycle char-write pulse to LCD driver.
REQ-015 lcd_charNum  output  4  position for lcd_wEn, held until next char issue.
REQ-016 lcd_line  output  64  registered line for lcd_wLineEn, held until next line issue.
REQ-017 busy  output  1  high in ISSUE and HOLD.
REQ-018 fifo_count  output  4  queue occupancy, 0..FIFO_DEPTH.
REQ-019 overflow  output  1  sticky; a char_req was dropped.

Function
REQ-020 FSM states IDLE, ISSUE, HOLD; IDLE with any pending work -> ISSUE next cycle; ISSUE -> HOLD always; HOLD lasts exactly HOLD_CYCLES cycles -> IDLE.
REQ-021 Selection in IDLE, fixed priority: line_req > queue non-empty > stat_req.
REQ-022 Grant pulse (line_gnt/stat_gnt) in the IDLE cycle of selection; lcd_wLineEn or lcd_wEn asserted during the following ISSUE cycle only.
REQ-023 Line grant: lcd_line <= line_data; stat grant: lcd_line <= stat_data; both drive lcd_wLineEn.
REQ-024 Char selection pops queue head into lcd_charNum; drives lcd_wEn.
REQ-025 Consecutive command pulses separated by exactly HOLD_CYCLES+2 cycles when work is continuously pending.
REQ-026 char_req with queue full: entry dropped, overflow set, fifo_count unchanged.
REQ-027 char_req in same cycle as a pop with queue full: push accepted, count unchanged.
REQ-028 line_gnt flushes the queue (fifo_count -> 0) the same cycle; a char_req in that cycle is discarded without setting overflow.
REQ-029 Requests arriving in ISSUE or HOLD wait; line_req/stat_req must stay high until granted; dropping them early withdraws them silently.
REQ-030 At most one of line_gnt, stat_gnt, lcd_wLineEn, lcd_wEn high per cycle.

Reset
REQ-031 reset low: state IDLE, hold counter 0, queue empty, all outputs 0 (lcd_line 64'h0, lcd_charNum 0, overflow 0), asynchronously.
REQ-032 reset asserted mid-ISSUE/HOLD aborts the command; first grant no earlier than the second rising edge after reset release.

Configuration
REQ-033 Macro LCD_SCHEDULER_STATUS_EN defined: status requester arbitrated per REQ-021.
REQ-034 Macro undefined: stat_req and stat_data ignored, stat_gnt constant 0; ports remain present.

Verification
REQ-035 HOLD_CYCLES=4, char_req pulses num 2 then 3 on consecutive cycles from IDLE -> lcd_wEn at t+1 (charNum 2) and t+7 (charNum 3).
REQ-036 line_req and stat_req high together in IDLE, line_data=64'h4142434400000000 -> line_gnt next edge, lcd_wLineEn with lcd_line=64'h4142434400000000, stat_gnt only after HOLD ends.
REQ-037 FIFO_DEPTH=4, five char_req pulses during HOLD -> fifo_count=4, overflow=1, four lcd_wEn pulses in push order.
REQ-038 Queue holding 3 entries, line_req asserted -> line_gnt, fifo_count=0, no lcd_wEn pulses follow.
REQ-039 reset low during HOLD with queue count 2 -> all outputs 0, fifo_count 0, no pulses until new requests.
REQ-040 Macro undefined, stat_req held high 100 cycles -> stat_gnt never asserts, busy stays 0.
